// File: rtl/id_operand_stage_if.sv
// id_operand_stage_if: ID-side instruction fields, register file read/writeback ports, pipeline control and ID/EX outputs.
//   slave  : the operand stage (consumes id_*/rd_data*/wb_*/flush/ex_hold; drives rd_addr*/stall_if/ex_*/bubble_cnt)
//   master : the surrounding core (the opposite directions)
interface id_operand_stage_if #(parameter int DW = 32, parameter int AW = 5, parameter int CW = 8);
  logic          id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic [DW-1:0] id_imm;
  logic [CW-1:0] id_ctrl;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          wb_wr_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          flush, ex_hold, stall_if;
  logic          ex_valid, ex_wr_en, ex_is_load;
  logic [DW-1:0] ex_op_a, ex_op_b, ex_imm;
  logic [CW-1:0] ex_ctrl;
  logic [AW-1:0] ex_dst, ex_rs, ex_rt;
  logic [15:0]   bubble_cnt;
  modport slave (
    input  id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, id_rs, id_rt, id_dst, id_imm, id_ctrl,
    input  rd_data1, rd_data2, wb_wr_en, wb_addr, wb_data, flush, ex_hold,
    output rd_addr1, rd_addr2, stall_if, ex_valid, ex_wr_en, ex_is_load,
    output ex_op_a, ex_op_b, ex_imm, ex_ctrl, ex_dst, ex_rs, ex_rt, bubble_cnt
  );
  modport master (
    output id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, id_rs, id_rt, id_dst, id_imm, id_ctrl,
    output rd_data1, rd_data2, wb_wr_en, wb_addr, wb_data, flush, ex_hold,
    input  rd_addr1, rd_addr2, stall_if, ex_valid, ex_wr_en, ex_is_load,
    input  ex_op_a, ex_op_b, ex_imm, ex_ctrl, ex_dst, ex_rs, ex_rt, bubble_cnt
  );
endinterface

// File: rtl/id_operand_stage.sv
// id_operand_stage: MIPS decode operand fetch with writeback bypass, load-use bubble insertion and the ID/EX register.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : id_operand_stage_if.slave carrying ID fields, register file/writeback ports, flush/hold and ex_* outputs
module id_operand_stage #(parameter int DW = 32, parameter int AW = 5, parameter int CW = 8) (
  input logic            clk,
  input logic            rst,
  id_operand_stage_if.slave bus
);
  typedef struct packed {
    logic          valid;
    logic          wr_en;
    logic          is_load;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] imm;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] dst;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
  } ex_t;
  ex_t           ex_q, ex_d, ex_load;
  logic [DW-1:0] op_a, op_b;
  logic          hz, bump;
  logic [15:0]   cnt_q;
  assign bus.rd_addr1 = bus.id_rs;
  assign bus.rd_addr2 = bus.id_rt;
  // The file commits at the edge, so a same-cycle writeback must be bypassed here; r0 always reads zero.
  assign op_a = bus.id_rs == '0 ? '0 : (bus.wb_wr_en && bus.wb_addr == bus.id_rs) ? bus.wb_data : bus.rd_data1;
  assign op_b = bus.id_rt == '0 ? '0 : (bus.wb_wr_en && bus.wb_addr == bus.id_rt) ? bus.wb_data : bus.rd_data2;
  assign hz = bus.id_valid & ex_q.valid & ex_q.is_load & ex_q.wr_en & (ex_q.dst != '0) &
              ((bus.id_uses_rs & (ex_q.dst == bus.id_rs)) | (bus.id_uses_rt & (ex_q.dst == bus.id_rt)));
  assign bus.stall_if = rst & ~bus.flush & (bus.ex_hold | hz);
  assign bump = ~bus.flush & ~bus.ex_hold & hz & ~&cnt_q;
  assign ex_load = '{valid: bus.id_valid, wr_en: bus.id_valid & bus.id_wr_en, is_load: bus.id_valid & bus.id_is_load,
                     op_a: op_a, op_b: op_b, imm: bus.id_imm, ctrl: bus.id_ctrl,
                     dst: bus.id_dst, rs: bus.id_rs, rt: bus.id_rt};
  // Flush and a load-use bubble both clear the whole ID/EX payload; hold outranks the bubble.
  assign ex_d = (bus.flush | (~bus.ex_hold & hz)) ? '0 : bus.ex_hold ? ex_q : ex_load;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_q + {15'd0, bump};
    end
  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_wr_en   = ex_q.wr_en;
  assign bus.ex_is_load = ex_q.is_load;
  assign bus.ex_op_a    = ex_q.op_a;
  assign bus.ex_op_b    = ex_q.op_b;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_ctrl    = ex_q.ctrl;
  assign bus.ex_dst     = ex_q.dst;
  assign bus.ex_rs      = ex_q.rs;
  assign bus.ex_rt      = ex_q.rt;
  assign bus.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed vectors against a behavioural ID/EX model plus hand-computed literal expectations.
module tb_id_operand_stage;
  localparam int DW = 32, AW = 5, CW = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  id_operand_stage_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();
  id_operand_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] rf [32];
  function automatic logic [DW-1:0] init_val(int i);
    return i == 5 ? 32'h11111111 : i == 3 ? 32'h5 : DW'(i) * 32'h01010101;
  endfunction
  always @(posedge clk)
    if (!rst) for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
    else if (bus.wb_wr_en) rf[bus.wb_addr] <= bus.wb_data;
  assign bus.rd_data1 = rf[bus.id_rs];
  assign bus.rd_data2 = rf[bus.id_rt];
  typedef struct packed {
    logic          valid;
    logic          wr_en;
    logic          is_load;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] imm;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] dst;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
  } ex_t;
  ex_t         m;
  logic [15:0] m_cnt;
  function automatic logic [DW-1:0] opnd(logic [AW-1:0] r);
    if (r == 0) return '0;
    if (bus.wb_wr_en && bus.wb_addr == r) return bus.wb_data;
    return rf[r];
  endfunction
  function automatic logic m_hz();
    logic reads_dst;
    reads_dst = (bus.id_uses_rs && bus.id_rs == m.dst) || (bus.id_uses_rt && bus.id_rt == m.dst);
    return bus.id_valid && m.valid && m.is_load && m.wr_en && m.dst != 0 && reads_dst;
  endfunction
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m     <= '0;
      m_cnt <= '0;
    end else if (bus.flush) m <= '0;
    else if (bus.ex_hold) m <= m;
    else if (m_hz()) begin
      m <= '0;
      if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
    end else
      m <= '{bus.id_valid, bus.id_valid & bus.id_wr_en, bus.id_valid & bus.id_is_load, opnd(bus.id_rs), opnd(bus.id_rt),
             bus.id_imm, bus.id_ctrl, bus.id_dst, bus.id_rs, bus.id_rt};
  function automatic void cmp(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  always @(negedge clk) begin
    cmp("stall_if", 64'(bus.stall_if), 64'(rst && !bus.flush && (bus.ex_hold || m_hz())));
    cmp("rd_addr1", 64'(bus.rd_addr1), 64'(bus.id_rs));
    cmp("rd_addr2", 64'(bus.rd_addr2), 64'(bus.id_rt));
    cmp("ex_valid", 64'(bus.ex_valid), 64'(m.valid));
    cmp("ex_wr_en", 64'(bus.ex_wr_en), 64'(m.wr_en));
    cmp("ex_is_load", 64'(bus.ex_is_load), 64'(m.is_load));
    cmp("ex_op_a", 64'(bus.ex_op_a), 64'(m.op_a));
    cmp("ex_op_b", 64'(bus.ex_op_b), 64'(m.op_b));
    cmp("ex_imm", 64'(bus.ex_imm), 64'(m.imm));
    cmp("ex_ctrl", 64'(bus.ex_ctrl), 64'(m.ctrl));
    cmp("ex_dst", 64'(bus.ex_dst), 64'(m.dst));
    cmp("ex_rs", 64'(bus.ex_rs), 64'(m.rs));
    cmp("ex_rt", 64'(bus.ex_rt), 64'(m.rt));
    cmp("bubble_cnt", 64'(bus.bubble_cnt), 64'(m_cnt));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_id(logic v, logic [AW-1:0] rs, logic [AW-1:0] rt, logic urs, logic urt,
                        logic [AW-1:0] dst, logic wr, logic ld, logic [DW-1:0] imm);
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_uses_rs = urs;
    bus.id_uses_rt = urt;
    bus.id_dst     = dst;
    bus.id_wr_en   = wr;
    bus.id_is_load = ld;
    bus.id_imm     = imm;
    bus.id_ctrl    = imm[CW-1:0] ^ {CW{1'b1}};
  endtask
  initial begin
    bus.flush = 0; bus.ex_hold = 0; bus.wb_wr_en = 0; bus.wb_addr = '0; bus.wb_data = '0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    bus.ex_hold = 1;
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 32'h10);
    #1 cmp("stall_in_reset", 64'(bus.stall_if), 64'd0);
    cmp("rst_valid", 64'(bus.ex_valid), 64'd0);
    cmp("rst_cnt", 64'(bus.bubble_cnt), 64'd0);
    bus.ex_hold = 0;
    tick();
    rst = 1;
    tick();
    // plain issue of a few patterns, including a writeback bypass on rt
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 32'hFFFF_FFF0);
    bus.wb_wr_en = 1; bus.wb_addr = 2; bus.wb_data = 32'hCAFEF00D;
    tick();
    cmp("lit_op_a_r1", 64'(bus.ex_op_a), 64'h01010101);
    cmp("lit_op_b_bypass_rt", 64'(bus.ex_op_b), 64'hCAFEF00D);
    bus.wb_wr_en = 0;
    set_id(0, 4, 6, 1, 1, 7, 1, 1, 32'h44);
    tick();
    cmp("lit_invalid_valid", 64'(bus.ex_valid), 64'd0);
    cmp("lit_invalid_wr_ld", 64'({bus.ex_wr_en, bus.ex_is_load}), 64'd0);
    for (int i = 1; i < 6; i++) begin
      set_id(1, AW'(i * 3), AW'(i * 5), 1, 1, AW'(i), i[0], 0, DW'(i * 32'h101));
      tick();
    end
    // writeback bypass on rs, then the committed value from the file
    set_id(1, 5, 0, 1, 0, 9, 1, 0, 32'h5);
    bus.wb_wr_en = 1; bus.wb_addr = 5; bus.wb_data = 32'hDEADBEEF;
    tick();
    cmp("lit_bypass_rs", 64'(bus.ex_op_a), 64'hDEADBEEF);
    bus.wb_wr_en = 0;
    tick();
    cmp("lit_committed_r5", 64'(bus.ex_op_a), 64'hDEADBEEF);
    // r0 always reads zero, written or bypassed
    set_id(1, 1, 0, 1, 1, 4, 1, 0, 32'h0);
    bus.wb_wr_en = 1; bus.wb_addr = 0; bus.wb_data = 32'h1234;
    #1 cmp("lit_r0_no_stall", 64'(bus.stall_if), 64'd0);
    tick();
    cmp("lit_r0_bypass", 64'(bus.ex_op_b), 64'd0);
    bus.wb_wr_en = 0;
    tick();
    cmp("lit_r0_file", 64'(bus.ex_op_b), 64'd0);
    // load-use: one bubble, then the consumer issues
    set_id(1, 1, 0, 1, 0, 8, 1, 1, 32'h4);
    tick();
    set_id(1, 8, 2, 1, 1, 9, 1, 0, 32'h0);
    #1 cmp("lit_lu_stall", 64'(bus.stall_if), 64'd1);
    tick();
    cmp("lit_lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
    cmp("lit_lu_cnt", 64'(bus.bubble_cnt), 64'd1);
    cmp("lit_lu_stall_drop", 64'(bus.stall_if), 64'd0);
    tick();
    cmp("lit_lu_issue", 64'({bus.ex_valid, bus.ex_rs}), 64'({1'b1, 5'd8}));
    // no false stall when rt matches but is not read
    set_id(1, 1, 0, 1, 0, 8, 1, 1, 32'h8);
    tick();
    set_id(1, 2, 8, 1, 0, 8, 1, 0, 32'h77);
    #1 cmp("lit_nofalse_stall", 64'(bus.stall_if), 64'd0);
    tick();
    cmp("lit_nofalse_valid", 64'(bus.ex_valid), 64'd1);
    cmp("lit_nofalse_cnt", 64'(bus.bubble_cnt), 64'd1);
    // flush outranks the hazard
    set_id(1, 1, 0, 1, 0, 8, 1, 1, 32'hC);
    tick();
    set_id(1, 8, 0, 1, 0, 9, 1, 0, 32'h0);
    bus.flush = 1;
    #1 cmp("lit_flush_stall", 64'(bus.stall_if), 64'd0);
    tick();
    bus.flush = 0;
    cmp("lit_flush_valid", 64'(bus.ex_valid), 64'd0);
    cmp("lit_flush_cnt", 64'(bus.bubble_cnt), 64'd1);
    // hold for three cycles while ID changes underneath
    set_id(1, 1, 2, 1, 1, 6, 1, 0, 32'h99);
    tick();
    bus.ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, AW'(10 + i), AW'(20 + i), 1, 1, AW'(i + 1), 1, i[0], DW'(i));
      #1 cmp("lit_hold_stall", 64'(bus.stall_if), 64'd1);
      tick();
      cmp("lit_hold_op_a", 64'(bus.ex_op_a), 64'h01010101);
      cmp("lit_hold_dst", 64'(bus.ex_dst), 64'd6);
    end
    bus.ex_hold = 0;
    tick();
    // hold with a pending load-use does not count a bubble
    set_id(1, 1, 0, 1, 0, 8, 1, 1, 32'h10);
    tick();
    set_id(1, 8, 0, 1, 0, 9, 1, 0, 32'h0);
    bus.ex_hold = 1;
    tick();
    cmp("lit_hold_hz_cnt", 64'(bus.bubble_cnt), 64'd1);
    bus.ex_hold = 0;
    tick();
    cmp("lit_after_hold_cnt", 64'(bus.bubble_cnt), 64'd2);
    tick();
    // reset between edges clears everything at once
    set_id(1, 3, 0, 1, 0, 2, 1, 0, 32'h1);
    tick();
    cmp("lit_pre_rst_op_a", 64'(bus.ex_op_a), 64'h5);
    rst = 0;
    #1 cmp("lit_async_valid", 64'(bus.ex_valid), 64'd0);
    cmp("lit_async_op_a", 64'(bus.ex_op_a), 64'd0);
    cmp("lit_async_cnt", 64'(bus.bubble_cnt), 64'd0);
    bus.ex_hold = 1;
    #1 cmp("lit_rst_gates_stall", 64'(bus.stall_if), 64'd0);
    tick();
    rst = 1;
    bus.ex_hold = 0;
    #1 cmp("lit_no_stall_after_rst", 64'(bus.stall_if), 64'd0);
    tick();
    cmp("lit_post_rst_valid", 64'(bus.ex_valid), 64'd1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
